alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
- Sequential ALU execution unit. It consumes the 4-bit ALU operation code produced by the opcode/ALUOp decode stage and executes it on two 16-bit operands.
- Single-cycle ops complete in one cycle. Rotates and shifts iterate one bit position per cycle.
- Valid/ready handshakes on both the input and output sides. It sits between decode/register-read and the writeback latch.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SHAMT_W, 4, width of the shift amount taken from b[SHAMT_W-1:0].

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; returns the block to IDLE and discards any op in flight.
- in_valid  input  1  op/a/b are valid.
- in_ready  output  1  block can accept an op.
- op  input  4  operation code; encodings listed under Behaviour.
- a  input  WIDTH  operand A (Rs).
- b  input  WIDTH  operand B (Rt/immediate); shift amount is b[3:0].
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- busy  output  1  high in SHIFT state.

Behaviour:
- Op encodings (shared package): ADD 0, SUB 1, XOR 2, ANDN 3, ROL 4, SLL 5, ROR 6, SRL 7, BTR 8, EQZ 9, SCO 10, LBI 11, SEQ 12, SLBI 13, SLT 14, SLE 15.
- Op semantics:
  - ADD: a+b. SUB: b-a. XOR: a^b. ANDN: a&~b.
  - BTR: bit-reverse of a.
  - EQZ: 1 if a==0, else 0.
  - SCO: carry-out of a+b, zero-extended.
  - LBI: b passed through unchanged.
  - SEQ: a==b. SLT: signed a<b. SLE: signed a<=b. Each yields 1 or 0, zero-extended.
  - SLBI: (a<<8) | b[7:0].
  - All arithmetic is modulo 2^WIDTH.
- FSM states: IDLE, SHIFT, DONE.
- Reset (async, rst_n=0): state=IDLE, result=0, out_valid=0, busy=0, count=0, in_ready=0 while rst_n is low. in_ready rises combinationally once rst_n=1 and state=IDLE.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==SHIFT).
- IDLE, on accept (in_valid & in_ready):
  - Non-shift op: result is registered at the accept edge; go to DONE. out_valid is high the cycle after accept (latency 1).
  - Shift op (4-7), shamt=0: result=a; go to DONE (latency 1).
  - Shift op (4-7), shamt=N>0: result=a, count=N, op latched; go to SHIFT.
- SHIFT, each cycle:
  - result is moved one position: ROL/ROR wrap the bit around; SLL/SRL fill with 0.
  - count decrements. When count reaches 1 on this edge, go to DONE.
  - out_valid therefore rises N+1 cycles after accept. shamt=15 takes 16 cycles.
- DONE: result and out_valid are held stable until out_ready=1, then go to IDLE. Throughput is at most one op per 2 cycles.
- in_valid while not in IDLE is ignored; the upstream stage must hold it.
- flush=1 at any state → IDLE next edge, out_valid=0; result is unchanged. flush has priority over accept in the same cycle.
- out_ready while not in DONE is ignored.
- rst_n asserted mid-SHIFT aborts immediately; there is no partial result.
- op, a and b are sampled only at accept; later changes have no effect.

Decomposition:
- Package alu_pkg holds the op encoding localparams (ADD..SLE) and the state encoding (IDLE/SHIFT/DONE, 2 bits). The opcode/ALUOp decoder also uses this package.
- Sub-module alu_shift_step: combinational one-bit step taking in[WIDTH], mode[1:0] (ROL/SLL/ROR/SRL) and producing out[WIDTH]. It is instantiated once and fed by the result register.
- Single-cycle ops are computed inline in alu_exec_seq.

Test Plan:
- Reset mid-SHIFT: ROL with b=8, assert rst_n low at cycle 3 → out_valid=0, result=0, busy=0 immediately; in_ready=1 after release.
- ADD: a=0x7FFF, b=0x0001 → out_valid the cycle after accept, result=0x8000. SCO with a=0xFFFF, b=0x0001 → result=0x0001.
- ROR: a=0x0001, b=0x0004 → busy for 4 cycles, out_valid at accept+5, result=0x1000. SRL: a=0x8000, b=0x000F → result=0x0001 at accept+16.
- Shift by 0: SLL with a=0xABCD, b=0x0000 → result=0xABCD at accept+1, busy never high.
- Backpressure: SLT with a=0xFFFF, b=0x0001 → result=0x0001. Hold out_ready=0 for 5 cycles → result stable, in_ready=0 throughout. One cycle of out_ready → IDLE.
- flush during SHIFT, and flush together with in_valid in IDLE → IDLE and no accept. The next op (SLBI with a=0x00AB, b=0x00CD) → result=0xABCD.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode and execute-FSM encodings.
// Used by the ALUOp decoder and alu_exec_seq.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ANDN = 4'd3;
  localparam logic [3:0] OP_ROL  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_BTR  = 4'd8;
  localparam logic [3:0] OP_EQZ  = 4'd9;
  localparam logic [3:0] OP_SCO  = 4'd10;
  localparam logic [3:0] OP_LBI  = 4'd11;
  localparam logic [3:0] OP_SEQ  = 4'd12;
  localparam logic [3:0] OP_SLBI = 4'd13;
  localparam logic [3:0] OP_SLT  = 4'd14;
  localparam logic [3:0] OP_SLE  = 4'd15;

  // Shift modes are the low two bits of ops 4..7
  localparam logic [1:0] MODE_ROL = 2'd0;
  localparam logic [1:0] MODE_SLL = 2'd1;
  localparam logic [1:0] MODE_ROR = 2'd2;
  localparam logic [1:0] MODE_SRL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction

endpackage

// File: rtl/alu_exec_seq_shift_step.sv
// One-bit rotate/shift step.
// Fed by the result register while iterating.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o
);

  // Move the word one position; rotates wrap, shifts zero-fill
  always_comb begin
    data_o = data_i;
    unique case (mode_i)
      MODE_ROL: data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
      MODE_SLL: data_o = {data_i[WIDTH-2:0], 1'b0};
      MODE_ROR: data_o = {data_i[0], data_i[WIDTH-1:1]};
      MODE_SRL: data_o = {1'b0, data_i[WIDTH-1:1]};
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential ALU execute unit with valid/ready on both sides.
// Single-cycle ops finish in one cycle, shifts iterate per bit.
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] count_q;
  logic [1:0]         mode_q;

  logic               accept;
  logic               shift_op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   step_res;

  assign accept   = in_valid & in_ready;
  assign shift_op = is_shift_op(op);
  assign shamt    = b[SHAMT_W-1:0];
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign result   = result_q;

  alu_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data_i(result_q),
    .mode_i(mode_q),
    .data_o(step_res)
  );

  // Single-cycle results; shift ops load the raw operand
  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = sum_ext[WIDTH-1:0];
      OP_SUB:  alu_res = b - a;
      OP_XOR:  alu_res = a ^ b;
      OP_ANDN: alu_res = a & ~b;
      OP_ROL,
      OP_SLL,
      OP_ROR,
      OP_SRL:  alu_res = a;
      OP_BTR: begin
        for (int i = 0; i < WIDTH; i++)
          alu_res[i] = a[WIDTH-1-i];
      end
      OP_EQZ:  alu_res[0] = (a == '0);
      OP_SCO:  alu_res[0] = sum_ext[WIDTH];
      OP_LBI:  alu_res = b;
      OP_SEQ:  alu_res[0] = (a == b);
      OP_SLBI: alu_res = (a << 8) | {{(WIDTH-8){1'b0}}, b[7:0]};
      OP_SLT:  alu_res[0] = ($signed(a) < $signed(b));
      OP_SLE:  alu_res[0] = ($signed(a) <= $signed(b));
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; flush beats accept
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept)
            state_d = (shift_op && shamt != '0) ? ST_SHIFT : ST_DONE;
        end
        ST_SHIFT: begin
          if (count_q == SHAMT_W'(1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      state_q == ST_IDLE:  in_ready  = rst_n;
      state_q == ST_SHIFT: busy      = 1'b1;
      state_q == ST_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load at accept, step while shifting, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      count_q  <= '0;
      mode_q   <= MODE_ROL;
    end else if (!flush) begin
      if (state_q == ST_IDLE && accept) begin
        result_q <= alu_res;
        mode_q   <= op[1:0];
        if (shift_op) count_q <= shamt;
      end else if (state_q == ST_SHIFT) begin
        result_q <= step_res;
        count_q  <= count_q - SHAMT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Randomized self-checking bench for alu_exec_seq.
// Compares against a plain-arithmetic reference model.
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  alu_exec_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [3:0] o,
                                        input logic [15:0] x,
                                        input logic [15:0] y);
    int n;
    int xi;
    int yi;
    int sx;
    int sy;
    logic [31:0] t;
    logic [15:0] r;
    n  = int'(y) % 16;
    xi = int'(x);
    yi = int'(y);
    sx = (xi >= 32768) ? xi - 65536 : xi;
    sy = (yi >= 32768) ? yi - 65536 : yi;
    t  = {16'h0, x};
    r  = '0;
    case (o)
      4'd0:  r = 16'((xi + yi) % 65536);
      4'd1:  r = 16'((yi - xi + 65536) % 65536);
      4'd2:  r = x ^ y;
      4'd3:  r = x & ~y;
      4'd4:  begin t = (t << n) | (t >> (16 - n)); r = t[15:0]; end
      4'd5:  r = 16'((xi * (1 << n)) % 65536);
      4'd6:  begin t = (t >> n) | (t << (16 - n)); r = t[15:0]; end
      4'd7:  r = 16'(xi / (1 << n));
      4'd8:  for (int i = 0; i < 16; i++) r[15-i] = x[i];
      4'd9:  r = (xi == 0) ? 16'd1 : 16'd0;
      4'd10: r = (xi + yi >= 65536) ? 16'd1 : 16'd0;
      4'd11: r = y;
      4'd12: r = (xi == yi) ? 16'd1 : 16'd0;
      4'd13: r = 16'(((xi % 256) * 256 + yi % 256) % 65536);
      4'd14: r = (sx < sy) ? 16'd1 : 16'd0;
      default: r = (sx <= sy) ? 16'd1 : 16'd0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] o,
                                   input logic [15:0] y);
    int n;
    n = int'(y) % 16;
    if (o >= 4 && o <= 7 && n != 0) return n + 1;
    return 1;
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [15:0] x,
                        input logic [15:0] y, input int hold);
    logic [15:0] exp;
    int lat;
    int k;
    exp = model(o, x, y);
    lat = model_lat(o, y);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 40) begin
      chk("busy_shift", busy, 1);
      chk("ready_shift", in_ready, 0);
      @(negedge clk);
      k++;
    end
    chk("latency", k, lat);
    chk("result", result, exp);
    chk("busy_done", busy, 0);
    chk("ready_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_result", result, exp);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("drain_valid", out_valid, 0);
    chk("drain_ready", in_ready, 1);
  endtask

  initial begin
    logic [15:0] x;
    logic [15:0] prev;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; op = '0; a = '0; b = '0;
    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", in_ready, 1);

    // Reset in the middle of a rotate
    @(negedge clk);
    op = 4'd4; a = 16'h1234; b = 16'h0008; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 1);

    // Directed cases
    run_op(4'd0,  16'h7FFF, 16'h0001, 0);
    run_op(4'd10, 16'hFFFF, 16'h0001, 0);
    run_op(4'd6,  16'h0001, 16'h0004, 0);
    run_op(4'd7,  16'h8000, 16'h000F, 0);
    run_op(4'd5,  16'hABCD, 16'h0000, 0);
    run_op(4'd14, 16'hFFFF, 16'h0001, 5);
    chk("slt_const", model(4'd14, 16'hFFFF, 16'h0001), 16'h0001);

    // Flush during a logical right shift
    x = 16'($urandom) | 16'h8000;
    @(negedge clk);
    op = 4'd7; a = x; b = 16'h000A; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_result", result, model(4'd7, x, 16'h0002));

    // Flush together with in_valid in IDLE blocks the accept
    prev = result;
    op = 4'd11; a = 16'h1111; b = 16'h2222; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flushacc_ready", in_ready, 1);
    chk("flushacc_valid", out_valid, 0);
    chk("flushacc_result", result, prev);
    run_op(4'd13, 16'h00AB, 16'h00CD, 1);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'h0000;
        1: rb = ra;
        2: ra = 16'hFFFF;
        3: rb = 16'h8000 | rb;
        default: ;
      endcase
      run_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
